// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants shared by the sync generator, the Pong top and the sync consumer.
// Derived start/end positions are inclusive.
package vga_timing_pkg;

    localparam int VGA_TOTAL_COLS    = 800;
    localparam int VGA_TOTAL_ROWS    = 525;
    localparam int VGA_ACTIVE_COLS   = 640;
    localparam int VGA_ACTIVE_ROWS   = 480;
    localparam int VGA_H_FRONT_PORCH = 16;
    localparam int VGA_H_SYNC_WIDTH  = 96;
    localparam int VGA_V_FRONT_PORCH = 10;
    localparam int VGA_V_SYNC_WIDTH  = 2;
    localparam int VGA_SYNC_ACTIVE_LOW = 1;

    localparam int VGA_H_SYNC_START = VGA_ACTIVE_COLS + VGA_H_FRONT_PORCH;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC_WIDTH - 1;
    localparam int VGA_V_SYNC_START = VGA_ACTIVE_ROWS + VGA_V_FRONT_PORCH;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC_WIDTH - 1;

    // Map an "in sync window" flag to the pin level for the chosen polarity.
    function automatic logic sync_level(input logic pulse, input bit active_low);
        return active_low ? ~pulse : pulse;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Purpose: wrapping 0..TERMINAL counter for one video axis, with a wrap pulse.
// Latency: count updates on the enabled edge; o_Wrap is combinational (enable AND count==TERMINAL).
// Backpressure: none; i_Enable=0 holds the count.
module vga_axis_counter #(
    parameter int TERMINAL = 799,
    parameter int WIDTH    = 10
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_Enable,
    output logic [WIDTH-1:0] o_Count,
    output logic             o_Wrap
);

    if (TERMINAL >= (2 ** WIDTH) || TERMINAL < 1) begin : g_bad_terminal
        $error("vga_axis_counter: TERMINAL does not fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TERMINAL);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_Count;
    logic             w_At_Last;

    assign w_At_Last = (r_Count == LAST);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Count <= '0;
        end else if (i_Enable) begin
            r_Count <= w_At_Last ? '0 : r_Count + ONE;
        end
    end

    assign o_Count = r_Count;
    assign o_Wrap  = i_Enable & w_At_Last;

endmodule

// File: rtl/vga_sync_gen.sv
// Purpose: free-running VGA timing: sync pulses, active flag, counts, frame strobe and frame counter.
// Latency: one enabled edge; outputs describe the counter value held before that edge.
// Backpressure: none; i_Enable=0 freezes everything except o_Frame_Start, which drops.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int TOTAL_COLS      = VGA_TOTAL_COLS,
    parameter int TOTAL_ROWS      = VGA_TOTAL_ROWS,
    parameter int ACTIVE_COLS     = VGA_ACTIVE_COLS,
    parameter int ACTIVE_ROWS     = VGA_ACTIVE_ROWS,
    parameter int H_FRONT_PORCH   = VGA_H_FRONT_PORCH,
    parameter int H_SYNC_WIDTH    = VGA_H_SYNC_WIDTH,
    parameter int V_FRONT_PORCH   = VGA_V_FRONT_PORCH,
    parameter int V_SYNC_WIDTH    = VGA_V_SYNC_WIDTH,
    parameter int SYNC_ACTIVE_LOW = VGA_SYNC_ACTIVE_LOW
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_L,
    input  logic                          i_Enable,
    output logic                          o_HSync,
    output logic                          o_VSync,
    output logic                          o_Active,
    output logic [$clog2(TOTAL_COLS)-1:0] o_Col_Count,
    output logic [$clog2(TOTAL_ROWS)-1:0] o_Row_Count,
    output logic                          o_Frame_Start,
    output logic [7:0]                    o_Frame_Count
);

    localparam int COL_W = $clog2(TOTAL_COLS);
    localparam int ROW_W = $clog2(TOTAL_ROWS);

    if ((ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH > TOTAL_COLS) ||
        (ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH > TOTAL_ROWS)) begin : g_bad_timing
        $error("vga_sync_gen: sync window extends past the total line/frame size");
    end

    if (ACTIVE_COLS < 1 || ACTIVE_ROWS < 1 || H_SYNC_WIDTH < 1 || V_SYNC_WIDTH < 1) begin : g_bad_sizes
        $error("vga_sync_gen: active area and sync widths must be at least one");
    end

    // All bounds are inclusive so every constant fits the counter width without overflow.
    localparam logic [COL_W-1:0] H_ACT_LAST   = COL_W'(ACTIVE_COLS - 1);
    localparam logic [ROW_W-1:0] V_ACT_LAST   = ROW_W'(ACTIVE_ROWS - 1);
    localparam logic [COL_W-1:0] H_SYNC_FIRST = COL_W'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [COL_W-1:0] H_SYNC_LAST  = COL_W'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
    localparam logic [ROW_W-1:0] V_SYNC_FIRST = ROW_W'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [ROW_W-1:0] V_SYNC_LAST  = ROW_W'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH - 1);
    localparam bit               ACT_LOW      = (SYNC_ACTIVE_LOW != 0);
    localparam logic             SYNC_IDLE    = ACT_LOW ? 1'b1 : 1'b0;

    logic [COL_W-1:0] w_Col;
    logic [ROW_W-1:0] w_Row;
    logic             w_Col_Wrap;
    logic             w_Row_En;
    logic             w_Row_Wrap;
    logic             w_In_HSync;
    logic             w_In_VSync;
    logic             w_In_Active;
    logic             w_At_Origin;

    logic             r_HSync;
    logic             r_VSync;
    logic             r_Active;
    logic [COL_W-1:0] r_Col_Count;
    logic [ROW_W-1:0] r_Row_Count;
    logic             r_Frame_Start;
    logic [7:0]       r_Frame_Count;
    logic [7:0]       r_Frames_Done;

    vga_axis_counter #(
        .TERMINAL (TOTAL_COLS - 1),
        .WIDTH    (COL_W)
    ) u_col_counter (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .i_Enable (i_Enable),
        .o_Count  (w_Col),
        .o_Wrap   (w_Col_Wrap)
    );

    assign w_Row_En = i_Enable & w_Col_Wrap;

    vga_axis_counter #(
        .TERMINAL (TOTAL_ROWS - 1),
        .WIDTH    (ROW_W)
    ) u_row_counter (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .i_Enable (w_Row_En),
        .o_Count  (w_Row),
        .o_Wrap   (w_Row_Wrap)
    );

    assign w_In_HSync  = (w_Col >= H_SYNC_FIRST) && (w_Col <= H_SYNC_LAST);
    assign w_In_VSync  = (w_Row >= V_SYNC_FIRST) && (w_Row <= V_SYNC_LAST);
    assign w_In_Active = (w_Col <= H_ACT_LAST) && (w_Row <= V_ACT_LAST);
    assign w_At_Origin = (w_Col == '0) && (w_Row == '0);

    // Completed frames count internally at the wrap; the output copy follows the
    // sample pipeline so it changes together with the (0,0) sample.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Frames_Done <= 8'd0;
        end else if (w_Row_Wrap) begin
            r_Frames_Done <= r_Frames_Done + 8'd1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_HSync       <= SYNC_IDLE;
            r_VSync       <= SYNC_IDLE;
            r_Active      <= 1'b0;
            r_Col_Count   <= '0;
            r_Row_Count   <= '0;
            r_Frame_Start <= 1'b0;
            r_Frame_Count <= 8'd0;
        end else begin
            r_Frame_Start <= 1'b0;
            if (i_Enable) begin
                r_HSync       <= sync_level(w_In_HSync, ACT_LOW);
                r_VSync       <= sync_level(w_In_VSync, ACT_LOW);
                r_Active      <= w_In_Active;
                r_Col_Count   <= w_Col;
                r_Row_Count   <= w_Row;
                r_Frame_Start <= w_At_Origin;
                r_Frame_Count <= r_Frames_Done;
            end
        end
    end

    assign o_HSync       = r_HSync;
    assign o_VSync       = r_VSync;
    assign o_Active      = r_Active;
    assign o_Col_Count   = r_Col_Count;
    assign o_Row_Count   = r_Row_Count;
    assign o_Frame_Start = r_Frame_Start;
    assign o_Frame_Count = r_Frame_Count;

endmodule
